// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter multiplexing NUM_REQ burst requesters
// onto one FIFO write port. A grant is decided in IDLE, which costs a
// one-cycle bubble, and is held in BURST until the owner's last beat or
// MAX_BURST beats. Grants are never preempted.
//
// Ports:
//   clk         clock, all state on the rising edge
//   reset       synchronous, active-high
//   req_valid   per-requester beat valid
//   req_last    per-requester last beat of burst
//   req_data    requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   beat accepted for requester i (owner only, same cycle)
//   fifo_full   full flag from the FIFO
//   fifo_wr_en  FIFO write enable (one entry per accepted beat)
//   fifo_wdata  FIFO write data (owner's data in BURST, 0 otherwise)
//   grant_id    index of the current or most recent owner
//   busy        high while in BURST
module fifo_wr_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned DATA_WIDTH  = 5,
   parameter int unsigned MAX_BURST   = 8,
   parameter int unsigned BURST_WIDTH = 4,
   parameter int unsigned ID_WIDTH    = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_wdata,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic                          busy
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] BURST = 1'b1;

   localparam logic [BURST_WIDTH-1:0] BEAT_LAST = BURST_WIDTH'(MAX_BURST - 1);
   localparam logic [ID_WIDTH-1:0]    ID_MAX    = ID_WIDTH'(NUM_REQ - 1);

   logic [0:0]             state, state_nxt;
   logic [ID_WIDTH-1:0]    rr_ptr, rr_ptr_nxt;
   logic [ID_WIDTH-1:0]    grant_nxt;
   logic [BURST_WIDTH-1:0] beat_cnt, beat_cnt_nxt;

   logic                   own_valid;
   logic                   own_last;
   logic [DATA_WIDTH-1:0]  own_data;
   logic                   xfer;
   logic                   burst_end;

   logic [2*NUM_REQ-1:0]   valid_dbl;
   logic [NUM_REQ-1:0]     valid_rot;
   logic                   any_valid;
   logic [ID_WIDTH-1:0]    winner;

   // Select the current owner's request signals.
   always_comb begin
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_data  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_id == ID_WIDTH'(i)) begin
            own_valid = req_valid[i];
            own_last  = req_last[i];
            own_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Circular search from rr_ptr: rotate valids so rr_ptr lands on bit 0,
   // take the lowest set bit, then map the offset back to a requester index.
   assign valid_dbl = {req_valid, req_valid} >> rr_ptr;
   assign valid_rot = valid_dbl[NUM_REQ-1:0];

   always_comb begin
      int unsigned sum;
      any_valid = 1'b0;
      winner    = rr_ptr;
      sum       = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!any_valid && valid_rot[k]) begin
            any_valid = 1'b1;
            sum       = 32'(rr_ptr) + k;
            if (sum >= NUM_REQ) begin
               sum = sum - NUM_REQ;
            end
            winner = ID_WIDTH'(sum);
         end
      end
   end

   assign xfer      = (state == BURST) && own_valid && !fifo_full;
   assign burst_end = xfer && (own_last || (beat_cnt == BEAT_LAST));

   // Next-state and next-register logic.
   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant_id;
      beat_cnt_nxt = beat_cnt;
      rr_ptr_nxt   = rr_ptr;
      case (state)
         IDLE: begin
            if (any_valid) begin
               state_nxt    = BURST;
               grant_nxt    = winner;
               beat_cnt_nxt = '0;
            end
         end
         BURST: begin
            if (xfer) begin
               beat_cnt_nxt = beat_cnt + BURST_WIDTH'(1);
            end
            if (burst_end) begin
               state_nxt  = IDLE;
               rr_ptr_nxt = (grant_id == ID_MAX) ? '0 : grant_id + ID_WIDTH'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State registers; reset overrides any in-flight burst.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_ptr_nxt;
         grant_id <= grant_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

   // Handshake outputs follow fifo_full in the same cycle; they are forced
   // low during reset so a burst being torn down cannot write.
   always_comb begin
      req_ready  = '0;
      fifo_wr_en = 1'b0;
      fifo_wdata = '0;
      if ((state == BURST) && !reset) begin
         fifo_wr_en = xfer;
         fifo_wdata = own_data;
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (grant_id == ID_WIDTH'(i)) && !fifo_full;
         end
      end
   end

   assign busy = (state == BURST);

endmodule
